// File: rtl/ctrl_pkg.sv
// Field layout of the decoder control word and helpers shared by the
// control pipeline and its benches.
package ctrl_pkg;

   localparam int AF_W   = 4;
   localparam int I_W    = 1;
   localparam int AMS_W  = 1;
   localparam int SHT_W  = 3;
   localparam int GPWE_W = 1;
   localparam int GPMS_W = 2;
   localparam int BF_W   = 4;
   localparam int PCMS_W = 2;
   localparam int MWE_W  = 1;

   localparam int FIXED_W = AF_W + I_W + AMS_W + SHT_W + GPWE_W + GPMS_W + BF_W + PCMS_W + MWE_W;

   localparam int DEFAULT_REG_W = 5;
   localparam logic [GPMS_W-1:0] GP_SEL_MEM = 2'b01;

   function automatic int ctrl_w(input int reg_w);
      return FIXED_W + 4 * reg_w;
   endfunction

   // Field LSB offsets, word packed MSB-first as af ... rd.
   localparam int RD_LSB = 0;
   function automatic int rt_lsb(input int reg_w);   return reg_w;          endfunction
   function automatic int rs_lsb(input int reg_w);   return 2 * reg_w;      endfunction
   function automatic int mwe_lsb(input int reg_w);  return 3 * reg_w;      endfunction
   function automatic int pcms_lsb(input int reg_w); return 3 * reg_w + 1;  endfunction
   function automatic int bf_lsb(input int reg_w);   return 3 * reg_w + 3;  endfunction
   function automatic int gpms_lsb(input int reg_w); return 3 * reg_w + 7;  endfunction
   function automatic int gpwe_lsb(input int reg_w); return 3 * reg_w + 9;  endfunction
   function automatic int cad_lsb(input int reg_w);  return 3 * reg_w + 10; endfunction
   function automatic int sht_lsb(input int reg_w);  return 4 * reg_w + 10; endfunction
   function automatic int ams_lsb(input int reg_w);  return 4 * reg_w + 13; endfunction
   function automatic int i_lsb(input int reg_w);    return 4 * reg_w + 14; endfunction
   function automatic int af_lsb(input int reg_w);   return 4 * reg_w + 15; endfunction

   typedef struct packed {
      logic [AF_W-1:0]          af;
      logic                     i;
      logic                     alu_mux_sel;
      logic [SHT_W-1:0]         shift_type;
      logic [DEFAULT_REG_W-1:0] cad;
      logic                     gp_we;
      logic [GPMS_W-1:0]        gp_mux_sel;
      logic [BF_W-1:0]          bf;
      logic [PCMS_W-1:0]        pc_mux_select;
      logic                     mem_wren;
      logic [DEFAULT_REG_W-1:0] rs;
      logic [DEFAULT_REG_W-1:0] rt;
      logic [DEFAULT_REG_W-1:0] rd;
   } ctrl_word_t;

endpackage

// File: rtl/decode_ctrl_pipe_stage.sv
// One {valid, word} pipeline register; clear beats load, otherwise it holds.
// An invalid stage always stores an all-zero word.
module ctrl_stage #(
   parameter int W = 39
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear_i,
   input  logic         load_i,
   input  logic         valid_i,
   input  logic [W-1:0] word_i,
   output logic         valid_o,
   output logic [W-1:0] word_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] word_q, word_d;

   always_comb begin
      valid_d = valid_q;
      word_d  = word_q;
      if (clear_i) begin
         valid_d = 1'b0;
         word_d  = '0;
      end else if (load_i) begin
         valid_d = valid_i;
         word_d  = valid_i ? word_i : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         word_q  <= '0;
      end else begin
         valid_q <= valid_d;
         word_q  <= word_d;
      end
   end

   assign valid_o = valid_q;
   assign word_o  = word_q;

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Packs decoder control fields into one word and carries it down a
// NUM_STAGES-deep pipe with stall, flush and load-use bubble insertion.
module decode_ctrl_pipe
   import ctrl_pkg::*;
#(
   parameter int NUM_STAGES = 3,
   parameter int REG_W      = 5,
   parameter int CNT_W      = 16,
   localparam int CTRL_W    = ctrl_w(REG_W)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            af,
   input  logic                  i,
   input  logic                  alu_mux_sel,
   input  logic [2:0]            shift_type,
   input  logic [REG_W-1:0]      cad,
   input  logic                  gp_we,
   input  logic [1:0]            gp_mux_sel,
   input  logic [3:0]            bf,
   input  logic [1:0]            pc_mux_select,
   input  logic                  mem_wren,
   input  logic [REG_W-1:0]      rs,
   input  logic [REG_W-1:0]      rt,
   input  logic [REG_W-1:0]      rd,
   input  logic                  stall,
   input  logic                  flush,
   output logic                  out_valid,
   output logic [CTRL_W-1:0]     out_word,
   output logic [NUM_STAGES-1:0] stage_valid,
   output logic                  hazard,
   output logic [CNT_W-1:0]      hazard_count
);

   localparam int CAD_LSB  = cad_lsb(REG_W);
   localparam int GPWE_LSB = gpwe_lsb(REG_W);
   localparam int GPMS_LSB = gpms_lsb(REG_W);

   logic [CTRL_W-1:0]                    in_word;
   logic [NUM_STAGES-1:0]                st_valid;
   logic [NUM_STAGES-1:0][CTRL_W-1:0]    st_word;
   logic [REG_W-1:0]                     s0_cad;
   logic                                 s0_gp_we;
   logic [1:0]                           s0_gp_sel;
   logic                                 take_input;
   logic [CNT_W-1:0]                     hcnt_q, hcnt_d;

   assign in_word = {af, i, alu_mux_sel, shift_type, cad, gp_we, gp_mux_sel,
                     bf, pc_mux_select, mem_wren, rs, rt, rd};

   assign s0_cad    = st_word[0][CAD_LSB +: REG_W];
   assign s0_gp_we  = st_word[0][GPWE_LSB];
   assign s0_gp_sel = st_word[0][GPMS_LSB +: 2];

   // Load-use: stage 0 is a load whose destination the incoming op reads.
   assign hazard = in_valid & st_valid[0] & s0_gp_we & (s0_gp_sel == GP_SEL_MEM) &
                   (s0_cad != '0) & ((s0_cad == rs) | (s0_cad == rt));

   assign in_ready   = ~stall & ~flush & ~hazard;
   assign take_input = in_valid & ~hazard;

   for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      logic              valid_in;
      logic [CTRL_W-1:0] word_in;

      if (gi == 0) begin : g_head
         assign valid_in = take_input;
         assign word_in  = take_input ? in_word : '0;
      end else begin : g_body
         assign valid_in = st_valid[gi-1];
         assign word_in  = st_word[gi-1];
      end

      ctrl_stage #(
         .W(CTRL_W)
      ) u_stage (
         .clk     (clk),
         .rst_n   (rst_n),
         .clear_i (flush),
         .load_i  (~stall),
         .valid_i (valid_in),
         .word_i  (word_in),
         .valid_o (st_valid[gi]),
         .word_o  (st_word[gi])
      );
   end

   always_comb begin
      hcnt_d = hcnt_q;
      if (!flush && !stall && hazard && !(&hcnt_q)) begin
         hcnt_d = hcnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_q <= '0;
      end else begin
         hcnt_q <= hcnt_d;
      end
   end

   assign out_valid    = st_valid[NUM_STAGES-1];
   assign out_word     = st_word[NUM_STAGES-1];
   assign stage_valid  = st_valid;
   assign hazard_count = hcnt_q;

endmodule
